vram_arbiter: RTL
=================

Name: vram_arbiter

Overview:
- Shares the single-port 128K video RAM between the scanout engine and the CPU bus.
- Video owns the port in every cycle where it requests it: phases 3/4 of each 8-pixel group in text mode, odd pixels in 320x200 mode.
- The CPU request is latched, issued into the first free cycle, then acknowledged with a one-cycle pulse.
- Sits between the CPU memory decoder, the video scanout block and the VRAM macro (synchronous read, 1-cycle latency).

Parameters:
AW, 17, VRAM address width (byte addressed, 0x00000-0x1FFFF)
MAX_WAIT, 15, starvation limit in cycles (used only with the optional feature)
WCW, 4, width of the wait counter; must satisfy 2^WCW > MAX_WAIT

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
vid_req  in  1  video needs the port this cycle
vid_a  in  AW  video address
vid_q  out  8  video read data; equals mem_q (pass-through)
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req
cpu_a  in  AW  CPU address
cpu_d  in  8  CPU write data
cpu_q  out  8  CPU read data; valid while cpu_ack = 1
cpu_ack  out  1  one-cycle completion pulse (registered)
mem_a  out  AW  VRAM address
mem_d  out  8  VRAM write data
mem_we  out  1  VRAM write enable
mem_q  in  8  VRAM read data, valid one cycle after mem_a
busy  out  1  CPU request latched and not yet acknowledged

Behaviour:
- Reset (async, reset_n = 0): state = IDLE; cpu_ack = 0; cpu_q = 0; latched address/data/we = 0; wait counter = 0. Any pending or in-flight CPU request is discarded with no ack.
- States: IDLE, PEND, DATA.
- IDLE: if cpu_req = 1 and cpu_ack = 0, latch cpu_a/cpu_d/cpu_we, clear the wait counter, go to PEND. cpu_req is ignored while cpu_ack = 1, so a held request is not re-accepted.
- PEND, vid_req = 1: video granted; wait counter increments and saturates at its maximum.
- PEND, vid_req = 0: CPU granted; latched address and data drive mem_a/mem_d; mem_we = latched we; go to DATA.
- DATA: on the edge leaving DATA, cpu_q <= mem_q if latched we = 0 (holds its old value for writes), cpu_ack <= 1, go to IDLE.
- cpu_ack is cleared on the following edge, so it is exactly one cycle wide.
- Port mux (combinational):
  - Grant = CPU only in PEND with the CPU slot taken.
  - Otherwise mem_a = vid_a, mem_we = 0, mem_d = latched data.
  - mem_we is never 1 outside a CPU-granted PEND cycle.
- Video is never stalled: vid_q is valid one cycle after any vid_req cycle.
- busy = state != IDLE.
- Minimum latency: cpu_req sampled at edge 1 -> issue during cycle 1-2 -> cpu_ack high after edge 3, i.e. 3 cycles.
- Each video request cycle in PEND adds one cycle of latency.
- Requester contract: cpu_a/cpu_d/cpu_we may change after acceptance, since the arbiter uses its latched copy. Requester drops cpu_req in the cycle it sees cpu_ack.
- Simultaneous cpu_req and vid_req in IDLE: the request is latched anyway. Video is unaffected.
- Address wrap: none; addresses pass through unmodified.

Optional Feature:
VRAM_STARVE_GUARD_EN:
- Defined: in PEND, once the wait counter reaches MAX_WAIT, the CPU is granted even if vid_req = 1. That video cycle receives the CPU's data (or stale data on a write), which is an accepted one-cycle glitch. An output starve_hit pulses for one cycle when this override occurs.
- Undefined: no override, so the CPU may wait indefinitely under continuous vid_req. starve_hit is tied to 0 and the counter logic is removed.

Test Plan:
- vid_req = 0, CPU write 0x5A to 0x18010 -> mem_we high exactly 1 cycle with mem_a = 0x18010; cpu_ack 3 cycles after cpu_req.
- Preload 0x18010 = 0xA5, CPU read with vid_req toggling 1,0 every cycle -> issue lands in the first vid_req = 0 cycle; cpu_q = 0xA5 with cpu_ack; video reads are uncorrupted.
- Text-mode pattern (vid_req high on phases 3,4 of 8), 100 random CPU read/write requests -> all acked, read-back matches writes, no mem_we during any vid_req cycle.
- cpu_req held high for 5 cycles after cpu_ack -> exactly one access and one ack until cpu_req drops and rises again.
- reset_n pulsed low while in PEND -> state IDLE, cpu_ack = 0, busy = 0 immediately; no write occurs.
- With VRAM_STARVE_GUARD_EN, MAX_WAIT = 15, vid_req held 1 -> CPU granted 16 cycles after entering PEND; starve_hit pulses once. Without the macro -> no grant while vid_req = 1.

Source files
------------

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video always wins its slot, one latched CPU access slips into free cycles.
// Optional starvation override enabled by defining VRAM_STARVE_GUARD_EN.
module vram_arbiter #(
  parameter int AW       = 17,
  parameter int MAX_WAIT = 15,
  parameter int WCW      = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_a,
  output logic [7:0]    vid_q,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_a,
  input  logic [7:0]    cpu_d,
  output logic [7:0]    cpu_q,
  output logic          cpu_ack,
  output logic [AW-1:0] mem_a,
  output logic [7:0]    mem_d,
  output logic          mem_we,
  input  logic [7:0]    mem_q,
  output logic          busy,
  output logic          starve_hit
);

  typedef enum logic [1:0] {IDLE, PEND, DATA} state_t;

  if (MAX_WAIT >= (1 << WCW)) begin : g_bad_wcw
    $error("vram_arbiter: WCW too narrow to hold MAX_WAIT");
  end

  state_t          r_state;
  state_t          w_next;
  logic [AW-1:0]   r_a;
  logic [7:0]      r_d;
  logic            r_we;
  logic [7:0]      r_q;
  logic            r_ack;
  logic            r_hold;
  logic            w_accept;
  logic            w_override;
  logic            w_grant;

  // r_hold blocks re-acceptance of a request still held high after its ack
  assign w_accept = (r_state == IDLE) && cpu_req && !r_ack && !r_hold;
  assign w_grant  = (r_state == PEND) && (!vid_req || w_override);

`ifdef VRAM_STARVE_GUARD_EN
  localparam logic [WCW-1:0] LP_MAX = WCW'(MAX_WAIT);
  logic [WCW-1:0] r_wait;

  assign w_override = (r_wait == LP_MAX);
  assign starve_hit = w_grant && vid_req;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wait <= '0;
    end else if (w_accept) begin
      r_wait <= '0;
    end else if ((r_state == PEND) && vid_req && !w_grant && (r_wait != '1)) begin
      r_wait <= r_wait + 1'b1;
    end
  end
`else
  assign w_override = 1'b0;
  assign starve_hit = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = PEND;
      PEND:    if (w_grant)  w_next = DATA;
      DATA:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_d     <= '0;
      r_we    <= 1'b0;
      r_q     <= '0;
      r_ack   <= 1'b0;
      r_hold  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ack   <= (r_state == DATA);
      if (w_accept) begin
        r_a  <= cpu_a;
        r_d  <= cpu_d;
        r_we <= cpu_we;
      end
      if ((r_state == DATA) && !r_we) r_q <= mem_q;
      if (r_state == DATA)  r_hold <= 1'b1;
      else if (!cpu_req)    r_hold <= 1'b0;
    end
  end

  assign mem_a   = w_grant ? r_a : vid_a;
  assign mem_we  = w_grant && r_we;
  assign mem_d   = r_d;
  assign vid_q   = mem_q;
  assign cpu_q   = r_q;
  assign cpu_ack = r_ack;
  assign busy    = (r_state != IDLE);

endmodule
